// File: rtl/hazard_detect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect_unit
//  Description : Tracks the ID-stage hazard class down EX/MEM/WB and produces
//                load-use stalls, redirect flushes, ID operand-forward selects,
//                MEM store-data forward select and saturating stall/flush
//                performance counters for a 5-stage pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rs1use_ID,
  input  logic             rs2_use_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic [4:0]       rd_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             Branch_ID,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] c_OP_NONE  = 2'b00;
  localparam logic [1:0] c_OP_ALU   = 2'b01;
  localparam logic [1:0] c_OP_LOAD  = 2'b10;
  localparam logic [1:0] c_OP_STORE = 2'b11;

  localparam logic [1:0] c_FWD_RF   = 2'b00;
  localparam logic [1:0] c_FWD_EXA  = 2'b01;
  localparam logic [1:0] c_FWD_MEMA = 2'b10;
  localparam logic [1:0] c_FWD_MEML = 2'b11;

  // Stage tracking state
  logic [1:0]       optype_ex_q, optype_ex_d;
  logic [4:0]       rd_ex_q, rd_ex_d;
  logic [4:0]       rs2_ex_q, rs2_ex_d;
  logic [1:0]       optype_mem_q;
  logic [4:0]       rd_mem_q;
  logic [4:0]       rs2_mem_q;
  logic [1:0]       optype_wb_q;
  logic [4:0]       rd_wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic w_stall;
  logic w_flush;

  // A stage result is forwardable only for a nonzero rd written by ALU/load.
  function automatic logic f_match(input logic [1:0] op, input logic [4:0] rd,
                                   input logic [4:0] idx);
    return (idx == rd) && (rd != 5'd0) && (op != c_OP_NONE) && (op != c_OP_STORE);
  endfunction

  // Operand select priority: youngest ALU result, then MEM ALU, then MEM load.
  // A match on a load still in EX yields regfile; the stall covers that case.
  function automatic logic [1:0] f_fwd(input logic use_i, input logic [4:0] idx,
                                       input logic [1:0] op_ex, input logic [4:0] rd_ex,
                                       input logic [1:0] op_mem, input logic [4:0] rd_mem);
    logic [1:0] sel;
    sel = c_FWD_RF;
    if (use_i) begin
      if (f_match(op_ex, rd_ex, idx) && (op_ex == c_OP_ALU))
        sel = c_FWD_EXA;
      else if (f_match(op_mem, rd_mem, idx) && (op_mem == c_OP_ALU))
        sel = c_FWD_MEMA;
      else if (f_match(op_mem, rd_mem, idx) && (op_mem == c_OP_LOAD))
        sel = c_FWD_MEML;
    end
    return sel;
  endfunction

  // Load-use stall; store data depending on the load is forwarded in MEM instead.
  always_comb begin
    w_stall = 1'b0;
    if ((optype_ex_q == c_OP_LOAD) && (rd_ex_q != 5'd0)) begin
      if (rs1use_ID && (rs1_ID == rd_ex_q))
        w_stall = 1'b1;
      else if (rs2_use_ID && (rs2_ID == rd_ex_q) && (hazard_optype_ID != c_OP_STORE))
        w_stall = 1'b1;
    end
  end

  // Redirect flush yields to stall; suppressed while reset is held.
  assign w_flush = Branch_ID & ~w_stall & ~rst;

  // Control and forwarding outputs
  always_comb begin
    PC_EN_IF        = ~w_stall;
    reg_FD_EN       = ~w_stall;
    reg_DE_flush    = w_stall;
    reg_FD_flush    = w_flush;
    forward_ctrl_A  = f_fwd(rs1use_ID, rs1_ID, optype_ex_q, rd_ex_q, optype_mem_q, rd_mem_q);
    forward_ctrl_B  = f_fwd(rs2_use_ID, rs2_ID, optype_ex_q, rd_ex_q, optype_mem_q, rd_mem_q);
    forward_ctrl_ls = (optype_mem_q == c_OP_STORE) && (optype_wb_q == c_OP_LOAD) &&
                      (rd_wb_q == rs2_mem_q) && (rd_wb_q != 5'd0);
  end

  // Next-state for EX stage and counters
  always_comb begin
    optype_ex_d = w_stall ? c_OP_NONE : hazard_optype_ID;
    rd_ex_d     = w_stall ? rd_ex_q  : rd_ID;
    rs2_ex_d    = w_stall ? rs2_ex_q : rs2_ID;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (w_flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Pipeline tracking registers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      optype_ex_q  <= c_OP_NONE;
      rd_ex_q      <= 5'd0;
      rs2_ex_q     <= 5'd0;
      optype_mem_q <= c_OP_NONE;
      rd_mem_q     <= 5'd0;
      rs2_mem_q    <= 5'd0;
      optype_wb_q  <= c_OP_NONE;
      rd_wb_q      <= 5'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      optype_ex_q  <= optype_ex_d;
      rd_ex_q      <= rd_ex_d;
      rs2_ex_q     <= rs2_ex_d;
      optype_mem_q <= optype_ex_q;
      rd_mem_q     <= rd_ex_q;
      rs2_mem_q    <= rs2_ex_q;
      optype_wb_q  <= optype_mem_q;
      rd_wb_q      <= rd_mem_q;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_detect_unit
//  Description : Self-checking bench for hazard_detect_unit with an
//                instruction-level reference model of the pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_detect_unit;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] c_MAX = '1;

  logic             clk;
  logic             rst;
  logic             rs1use_ID, rs2_use_ID, Branch_ID;
  logic [1:0]       hazard_optype_ID;
  logic [4:0]       rd_ID, rs1_ID, rs2_ID;
  logic             PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_ls;
  logic [1:0]       forward_ctrl_A, forward_ctrl_B;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_detect_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1use_ID(rs1use_ID), .rs2_use_ID(rs2_use_ID),
    .hazard_optype_ID(hazard_optype_ID),
    .rd_ID(rd_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .Branch_ID(Branch_ID),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: instructions in flight ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
    logic [4:0] rs2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_stalls, m_flushes;

  logic       e_stall, e_flush, e_ls;
  logic [1:0] e_fa, e_fb;

  function automatic logic writes(input ins_t s, input logic [4:0] r);
    return (r != 0) && (s.rd == r) && (s.op == 2'b01 || s.op == 2'b10);
  endfunction

  function automatic logic [1:0] pick(input logic u, input logic [4:0] r,
                                      input ins_t ex, input ins_t mem);
    if (!u) return 2'b00;
    if (writes(ex, r) && ex.op == 2'b01) return 2'b01;
    if (writes(mem, r)) return (mem.op == 2'b01) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_eval();
    e_stall = (m_ex.op == 2'b10) && (m_ex.rd != 0) &&
              ((rs1use_ID && rs1_ID == m_ex.rd) ||
               (rs2_use_ID && rs2_ID == m_ex.rd && hazard_optype_ID != 2'b11));
    e_flush = Branch_ID && !e_stall && !rst;
    e_fa    = pick(rs1use_ID, rs1_ID, m_ex, m_mem);
    e_fb    = pick(rs2_use_ID, rs2_ID, m_ex, m_mem);
    e_ls    = (m_mem.op == 2'b11) && (m_wb.op == 2'b10) &&
              (m_wb.rd == m_mem.rs2) && (m_wb.rd != 0);
  endtask

  // Advance one clock; model moves every instruction one stage along.
  task automatic tick();
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    if (e_stall) m_ex.op = 2'b00;
    else m_ex = '{op: hazard_optype_ID, rd: rd_ID, rs2: rs2_ID};
    if (e_stall && m_stalls < int'(c_MAX))  m_stalls++;
    if (e_flush && m_flushes < int'(c_MAX)) m_flushes++;
    #2;
  endtask

  // Present one ID instruction and move to the sample point mid-cycle.
  task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u1, input logic u2, input logic br);
    hazard_optype_ID = op; rd_ID = rd; rs1_ID = r1; rs2_ID = r2;
    rs1use_ID = u1; rs2_use_ID = u2; Branch_ID = br;
    #5;
    model_eval();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive(2'b01, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls} !== 9'b1100_0000_0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 110000000",
               {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls});
    end
    n_vec++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fwd_alu();
    do_reset();
    drive(2'b01, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0); tick();      // add x5
    drive(2'b01, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);              // addi x6,x5,1
    n_vec++;
    if (forward_ctrl_A !== 2'b01 || PC_EN_IF !== 1'b1) begin
      n_err++;
      $display("FAIL fwd_ex_alu: fA=%b pc_en=%b want 01/1", forward_ctrl_A, PC_EN_IF);
    end
    tick();
    drive(2'b01, 5'd9, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0);              // reads x5
    n_vec++;
    if (forward_ctrl_A !== 2'b10 || forward_ctrl_B !== 2'b00) begin
      n_err++;
      $display("FAIL fwd_mem_alu: fA=%b fB=%b want 10/00", forward_ctrl_A, forward_ctrl_B);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(2'b10, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();      // lw x7
    drive(2'b01, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);              // add x8,x7,x1
    n_vec++;
    if ({PC_EN_IF, reg_FD_EN, reg_DE_flush} !== 3'b001) begin
      n_err++;
      $display("FAIL load_use_stall: pc/fd/de=%b want 001", {PC_EN_IF, reg_FD_EN, reg_DE_flush});
    end
    tick();
    drive(2'b01, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);              // held add
    n_vec++;
    if (forward_ctrl_A !== 2'b11 || PC_EN_IF !== 1'b1 || stall_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL load_use_fwd: fA=%b pc_en=%b stall_cnt=%0d want 11/1/1",
               forward_ctrl_A, PC_EN_IF, stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_store();
    do_reset();
    drive(2'b10, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();      // lw x9
    drive(2'b11, 5'd0, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);              // sw x9,0(x2)
    n_vec++;
    if (PC_EN_IF !== 1'b1 || forward_ctrl_B !== 2'b00) begin
      n_err++;
      $display("FAIL store_nostall: pc_en=%b fB=%b want 1/00", PC_EN_IF, forward_ctrl_B);
    end
    tick();
    drive(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (forward_ctrl_ls !== 1'b1) begin
      n_err++;
      $display("FAIL store_ls_fwd: ls=%b want 1", forward_ctrl_ls);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive(2'b10, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0); tick();      // lw x0
    drive(2'b01, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);              // add x3,x0,x0
    n_vec++;
    if (PC_EN_IF !== 1'b1 || forward_ctrl_A !== 2'b00 || forward_ctrl_B !== 2'b00) begin
      n_err++;
      $display("FAIL x0_dep: pc_en=%b fA=%b fB=%b want 1/00/00", PC_EN_IF, forward_ctrl_A, forward_ctrl_B);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (reg_FD_flush !== 1'b1) begin
      n_err++;
      $display("FAIL branch_flush: flush=%b want 1", reg_FD_flush);
    end
    tick();
    drive(2'b10, 5'd4, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);              // lw x4
    n_vec++;
    if (flush_cnt !== 4'd1 || reg_FD_flush !== 1'b0) begin
      n_err++;
      $display("FAIL branch_cnt: flush_cnt=%0d flush=%b want 1/0", flush_cnt, reg_FD_flush);
    end
    tick();
    drive(2'b00, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);              // branch on x4
    n_vec++;
    if (reg_FD_flush !== 1'b0 || PC_EN_IF !== 1'b0) begin
      n_err++;
      $display("FAIL branch_in_stall: flush=%b pc_en=%b want 0/0", reg_FD_flush, PC_EN_IF);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(2'b10, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(2'b01, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_mid_stall: pc/fd/fdfl/defl=%b want 1100",
               {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush});
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2'b10, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();
      drive(2'b01, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0); tick();
      if (i == 13) begin
        drive(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (stall_cnt !== 4'd14) begin
          n_err++;
          $display("FAIL sat_preload: stall_cnt=%0d want 14", stall_cnt);
        end
        tick();
      end
    end
    drive(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (stall_cnt !== c_MAX) begin
      n_err++;
      $display("FAIL sat_hold: stall_cnt=%0d want %0d", stall_cnt, c_MAX);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      n_vec++;
      if ({PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls} !==
          {!e_stall, !e_stall, e_flush, e_stall, e_fa, e_fb, e_ls}) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                 {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls},
                 {!e_stall, !e_stall, e_flush, e_stall, e_fa, e_fb, e_ls});
      end
      n_vec++;
      if (stall_cnt !== CNT_W'(m_stalls) || flush_cnt !== CNT_W'(m_flushes)) begin
        n_err++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                 stall_cnt, flush_cnt, m_stalls, m_flushes);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    rs1use_ID = 1'b0; rs2_use_ID = 1'b0; Branch_ID = 1'b0;
    hazard_optype_ID = 2'b00; rd_ID = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
    model_reset();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_load_store();
    test_x0();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
